pix_stream_tx: RTL and testbench
================================

Name: pix_stream_tx

Overview:
Frame-buffered pixel transmitter that drives the conv pipeline's input stream (data/valid/sop/eop, gated by clk_en and the downstream ready).
- Host side writes one IMG_WIDTH x IMG_HEIGHT multi-channel frame into an internal buffer, then pulses start.
- The block replays the frame in raster order with sop/eop framing and honours backpressure.
- It is the source end of the same stream interface that conv blocks consume.

Parameters:
PIX_WIDTH, 8, bits per channel sample
IN_DIMENSION, 1, channels per pixel (packed on o_data)
IMG_WIDTH, 28, pixels per row
IMG_HEIGHT, 28, rows per frame

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is synchronous and active-high
clk_en  in  1  global enable; when low all state holds (reset still acts)
i_wr_en  in  1  frame-buffer write strobe
i_wr_addr  in  ADDR_W  raster address = row*IMG_WIDTH+col
i_wr_data  in  [IN_DIMENSION-1:0][PIX_WIDTH-1:0]  pixel to store
i_start  in  1  start-frame pulse
i_ready  in  1  downstream can accept (conv ready)
o_data  out  [IN_DIMENSION-1:0][PIX_WIDTH-1:0]  pixel
o_valid  out  1  o_data valid
o_sop  out  1  first pixel of frame, qualified by o_valid
o_eop  out  1  last pixel of frame, qualified by o_valid
o_busy  out  1  high from accepted start until frame-end handshake
o_done  out  1  one-cycle pulse after the eop handshake
o_wr_err  out  1  sticky: write attempted while busy

Behaviour:
- Reset: o_valid, o_sop, o_eop, o_busy, o_done and o_wr_err = 0; o_data = 0; state IDLE; counters 0. Buffer contents are not cleared.
- All register updates, including RAM writes, require clk_en=1.
- Transfer occurs on an edge with clk_en & o_valid & i_ready.
- Writes: accepted only in IDLE. A write while busy is dropped and sets o_wr_err, which stays set until rst. i_wr_addr >= NPIX is dropped, with no error.
- FSM:
  - IDLE: i_start moves to RUN, issues read of address 0 and asserts o_busy next edge.
  - RUN: prefetches sequentially. First o_valid appears 2 enabled cycles after start is sampled (1-cycle synchronous RAM read plus output register).
  - RUN to DRAIN: after the last address is read.
  - DRAIN to IDLE: on the eop transfer. o_busy drops and o_done pulses on that same edge.
  - i_start outside IDLE is ignored.
- Backpressure:
  - While o_valid & !i_ready, o_data, o_sop and o_eop hold stable.
  - A 1-entry skid register absorbs the in-flight RAM read, so no pixel is lost or duplicated.
  - With i_ready held high, throughput is 1 pixel per enabled cycle with no bubbles inside a frame.
- Framing: o_sop only with pixel 0; o_eop only with pixel NPIX-1. For a 1x1 image both are asserted on the same beat.
- Column wraps at IMG_WIDTH-1 with row increment. Row wraps to 0 after the last pixel.
- Reset mid-frame: the stream aborts with no eop, outputs return to reset values next edge, and the buffer is retained.
- Simultaneous i_wr_en and i_start in IDLE: the write is committed and start is accepted. The read of address 0 returns new data when addresses collide (write-first RAM).

Optional Feature:
PIX_TX_LOOP_EN. When defined, an extra input i_loop (1 bit) exists.
- If i_loop=1 at the eop transfer, the FSM stays in RUN, o_done still pulses, o_busy stays high, and pixel 0 (with sop) is presented on the next enabled cycle, giving gapless frame repetition.
- When not defined, the port is absent and every frame needs a new i_start.

Decomposition:
- Package pix_stream_pkg holds:
  - localparams NPIX = IMG_WIDTH*IMG_HEIGHT and ADDR_W = $clog2(NPIX), as functions of parameters, supplied via a parameterised function or macro;
  - typedef enum tx_state_t {IDLE, RUN, DRAIN}.
- One sub-module: pix_frame_ram, a simple dual-port RAM with 1 write and 1 read port, synchronous 1-cycle read, write-first, width IN_DIMENSION*PIX_WIDTH, depth NPIX.

Test Plan:
- 4x3 image, IN_DIMENSION=2, buffer loaded with addr-indexed values, i_ready=1, start at cycle 10:
  - o_valid first high at cycle 12 and 12 consecutive beats with data = written values;
  - sop on beat 0, eop on beat 11;
  - o_done at the eop edge.
- Same frame, i_ready toggling pseudo-randomly: output sequence identical, data/sop/eop stable during every stall, no drop or duplicate.
- clk_en low for 5 cycles mid-frame: no state change, beats resume in exact order.
- Write during RUN: data ignored, o_wr_err=1 and stays set. Second frame replays the original data.
- Reset at beat 6: next edge o_valid=0 and o_busy=0. A new start replays from pixel 0 with sop.
- IMG_WIDTH=IMG_HEIGHT=1: a single beat with sop=eop=1. With PIX_TX_LOOP_EN and i_loop=1, beats repeat every cycle, each with sop=eop=1.

Source files
------------

// File: rtl/pix_stream_pkg.sv
// Shared state type and frame-geometry helpers for the pixel stream transmitter.
package pix_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } tx_state_t;

  function automatic int npix(input int img_width, input int img_height);
    return img_width * img_height;
  endfunction

  // Keep at least one address bit so a 1x1 frame still has a legal bus.
  function automatic int addr_w(input int img_width, input int img_height);
    return (npix(img_width, img_height) > 1) ? $clog2(npix(img_width, img_height)) : 1;
  endfunction

endpackage

// File: rtl/pix_stream_tx_if.sv
// Pixel stream bus between the transmitter (master) and a conv block (slave).
interface pix_stream_tx_if #(
  parameter int PIX_WIDTH    = 8,
  parameter int IN_DIMENSION = 1
);
  // A beat moves on a clock edge where clk_en, o_valid and i_ready are all high; while
  // o_valid is high and i_ready low, o_data/o_sop/o_eop hold. sop/eop are qualified by o_valid.
  logic [IN_DIMENSION-1:0][PIX_WIDTH-1:0] o_data;
  logic                                   o_valid;
  logic                                   o_sop;
  logic                                   o_eop;
  logic                                   i_ready;

  modport master (output o_data, o_valid, o_sop, o_eop, input i_ready);
  modport slave  (input o_data, o_valid, o_sop, o_eop, output i_ready);
endinterface

// File: rtl/pix_frame_ram.sv
// Simple dual-port frame buffer: one write port, one write-first synchronous read port.
module pix_frame_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 784,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              clk_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= (wr_en && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
    end
  end
endmodule

// File: rtl/pix_stream_tx.sv
// Frame-buffered pixel stream source: host loads a frame, i_start replays it in raster order.
// Optional macro PIX_TX_LOOP_EN adds i_loop for gapless frame repetition.
module pix_stream_tx
  import pix_stream_pkg::*;
#(
  parameter int  PIX_WIDTH    = 8,
  parameter int  IN_DIMENSION = 1,
  parameter int  IMG_WIDTH    = 28,
  parameter int  IMG_HEIGHT   = 28,
  localparam int NPIX         = npix(IMG_WIDTH, IMG_HEIGHT),
  localparam int ADDR_W       = addr_w(IMG_WIDTH, IMG_HEIGHT)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   clk_en,
  input  logic                                   i_wr_en,
  input  logic [ADDR_W-1:0]                      i_wr_addr,
  input  logic [IN_DIMENSION-1:0][PIX_WIDTH-1:0] i_wr_data,
  input  logic                                   i_start,
`ifdef PIX_TX_LOOP_EN
  input  logic                                   i_loop,
`endif
  pix_stream_tx_if.master                        tx,
  output logic                                   o_busy,
  output logic                                   o_done,
  output logic                                   o_wr_err,
  output tx_state_t                              o_state
);
  localparam int DATA_W = IN_DIMENSION * PIX_WIDTH;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W:0]   NPIX_W    = (ADDR_W + 1)'(NPIX);
`ifdef PIX_TX_LOOP_EN
  localparam bit LOOP_BUILD = 1'b1;
`else
  localparam bit LOOP_BUILD = 1'b0;
`endif

  typedef logic [IN_DIMENSION-1:0][PIX_WIDTH-1:0] pix_t;

  tx_state_t         state, state_nxt;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr;
  logic              rd_en, pend, pend_sop, pend_eop;
  logic              skid_v, skid_sop, skid_eop;
  logic              out_v, out_sop, out_eop;
  pix_t              skid_data, out_data, ram_pix;
  logic [DATA_W-1:0] ram_q;
  logic [1:0]        held;
  logic              xfer, eop_xfer, looping, flush, can_issue, wr_ok;

`ifdef PIX_TX_LOOP_EN
  assign looping = i_loop;
`else
  assign looping = 1'b0;
`endif

  assign ram_pix   = ram_q;
  assign xfer      = out_v && tx.i_ready;
  assign eop_xfer  = xfer && out_eop;
  assign flush     = eop_xfer && !looping;
  assign wr_ok     = i_wr_en && (state == IDLE) && ({1'b0, i_wr_addr} < NPIX_W);
  // Beats held after this edge; a new read may only launch if one slot stays free for it.
  assign held      = {1'b0, out_v} + {1'b0, skid_v} + {1'b0, pend} - {1'b0, xfer};
  assign can_issue = (held <= 2'd1);

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    rd_addr   = rd_addr_q;
    unique case (state)
      IDLE: if (i_start) begin
        rd_en     = 1'b1;
        rd_addr   = '0;
        state_nxt = (NPIX == 1) ? DRAIN : RUN;
      end
      RUN: begin
        rd_en = can_issue;
        if (can_issue && rd_addr_q == LAST_ADDR) state_nxt = DRAIN;
      end
      // Looping builds keep prefetching the next frame; a non-looping eop flushes it.
      DRAIN:   rd_en = LOOP_BUILD && can_issue;
      default: state_nxt = IDLE;
    endcase
    if (eop_xfer) state_nxt = !looping ? IDLE : ((rd_en && rd_addr == LAST_ADDR) ? DRAIN : RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rd_addr_q <= '0;
      pend      <= 1'b0;
      pend_sop  <= 1'b0;
      pend_eop  <= 1'b0;
      skid_v    <= 1'b0;
      skid_sop  <= 1'b0;
      skid_eop  <= 1'b0;
      skid_data <= '0;
      out_v     <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_data  <= '0;
      o_done    <= 1'b0;
      o_wr_err  <= 1'b0;
    end else if (clk_en) begin
      state    <= state_nxt;
      o_done   <= eop_xfer;
      pend     <= rd_en && !flush;
      pend_sop <= (rd_addr == '0);
      pend_eop <= (rd_addr == LAST_ADDR);
      if (i_wr_en && state != IDLE) o_wr_err <= 1'b1;
      if (flush)      rd_addr_q <= '0;
      else if (rd_en) rd_addr_q <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + 1'b1;

      if (flush) begin
        out_v  <= 1'b0;
        skid_v <= 1'b0;
      end else if (!out_v || xfer) begin
        if (skid_v) begin
          out_v     <= 1'b1;
          out_data  <= skid_data;
          out_sop   <= skid_sop;
          out_eop   <= skid_eop;
          skid_v    <= pend;
          skid_data <= ram_pix;
          skid_sop  <= pend_sop;
          skid_eop  <= pend_eop;
        end else begin
          out_v <= pend;
          if (pend) begin
            out_data <= ram_pix;
            out_sop  <= pend_sop;
            out_eop  <= pend_eop;
          end
        end
      end else if (pend) begin
        skid_v    <= 1'b1;
        skid_data <= ram_pix;
        skid_sop  <= pend_sop;
        skid_eop  <= pend_eop;
      end
    end
  end

  pix_frame_ram #(.DATA_W(DATA_W), .DEPTH(NPIX), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .clk_en  (clk_en),
    .wr_en   (wr_ok),
    .wr_addr (i_wr_addr),
    .wr_data (i_wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  assign tx.o_data  = out_data;
  assign tx.o_valid = out_v;
  assign tx.o_sop   = out_sop;
  assign tx.o_eop   = out_eop;
  assign o_busy     = (state != IDLE);
  assign o_state    = state;
endmodule

// File: tb/tb_pix_stream_tx.sv
// Bench for pix_stream_tx: a 4x3x2 instance checked against a frame-queue model, plus a 1x1 instance.
// Define PIX_TX_LOOP_EN to also exercise the looping path.
module tb_pix_stream_tx;
  import pix_stream_pkg::*;

  localparam int W = 4, H = 3, NP = W * H;
  typedef logic [1:0][7:0] pix_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst = 1'b1, clk_en = 1'b1, wr_en = 1'b0, start = 1'b0, ready = 1'b1, loop_m = 1'b0;
  logic [3:0] wr_addr = '0;
  pix_t wr_data = '0;
  logic m_busy, m_done, m_err;
  tx_state_t m_state;

  pix_stream_tx_if #(.PIX_WIDTH(8), .IN_DIMENSION(2)) tx_if ();
  assign tx_if.i_ready = ready;

  pix_stream_tx #(.PIX_WIDTH(8), .IN_DIMENSION(2), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_start(start),
`ifdef PIX_TX_LOOP_EN
    .i_loop(loop_m),
`endif
    .tx(tx_if), .o_busy(m_busy), .o_done(m_done), .o_wr_err(m_err), .o_state(m_state));

  logic s_rst = 1'b1, s_clk_en = 1'b1, s_wr_en = 1'b0, s_start = 1'b0, s_ready = 1'b1, s_loop = 1'b0;
  logic [0:0] s_wr_addr = '0;
  logic [7:0] s_wr_data = '0;
  logic s_busy, s_done, s_err;
  tx_state_t s_state;

  pix_stream_tx_if #(.PIX_WIDTH(8), .IN_DIMENSION(1)) s_if ();
  assign s_if.i_ready = s_ready;

  pix_stream_tx #(.PIX_WIDTH(8), .IN_DIMENSION(1), .IMG_WIDTH(1), .IMG_HEIGHT(1)) s_dut (
    .clk(clk), .rst(s_rst), .clk_en(s_clk_en), .i_wr_en(s_wr_en), .i_wr_addr(s_wr_addr),
    .i_wr_data(s_wr_data), .i_start(s_start),
`ifdef PIX_TX_LOOP_EN
    .i_loop(s_loop),
`endif
    .tx(s_if), .o_busy(s_busy), .o_done(s_done), .o_wr_err(s_err), .o_state(s_state));

  // ---------------- scoreboard ----------------
  int n_checks = 0, n_pass = 0;
  logic [17:0] exp_q[$];  // {sop, eop, data}
  pix_t mem_m [NP];
  logic in_frame = 1'b0, done_m = 1'b0, err_m = 1'b0, mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic void push_frame();
    for (int i = 0; i < NP; i++) exp_q.push_back({i == 0, i == NP - 1, mem_m[i]});
  endfunction

  always @(negedge clk) begin : monitor
    logic was_busy;
    logic [17:0] beat;
    if (mon_en) begin
      chk("busy", 32'(m_busy), 32'(in_frame));
      chk("done", 32'(m_done), 32'(done_m));
      chk("wr_err", 32'(m_err), 32'(err_m));
      if (exp_q.size() == 0) chk("valid_idle", 32'(tx_if.o_valid), 32'(0));
      else if (tx_if.o_valid) chk("beat", 32'({tx_if.o_sop, tx_if.o_eop, tx_if.o_data}), 32'(exp_q[0]));
      // advance the model to the state after the coming edge
      if (rst) begin
        exp_q.delete();
        in_frame = 1'b0; done_m = 1'b0; err_m = 1'b0;
      end else if (clk_en) begin
        was_busy = in_frame;
        done_m   = 1'b0;
        if (tx_if.o_valid && ready && exp_q.size() != 0) begin
          beat = exp_q.pop_front();
          if (beat[16]) begin
            done_m = 1'b1;
            if (loop_m) push_frame();
            else in_frame = 1'b0;
          end
        end
        if (wr_en) begin
          if (was_busy) err_m = 1'b1;
          else if (int'(wr_addr) < NP) mem_m[wr_addr] = wr_data;
        end
        if (start && !was_busy) begin
          in_frame = 1'b1;
          push_frame();
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write_pix(input logic [3:0] a, input pix_t d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_frame(input int max_cyc, input bit rnd_ready, input string tag);
    bit seen = 1'b0;
    int k = 0;
    while (!seen && k < max_cyc) begin
      if (rnd_ready) ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      seen = m_done;
      tick();
      k++;
    end
    ready = 1'b1;
    chk(tag, 32'(seen), 32'(1));
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int t0, first, nvalid, eop_c, done_c, n;
    logic first_sop;
    logic [15:0] last_d;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(tx_if.o_valid), 32'(0));
    chk("rst_data", 32'(tx_if.o_data), 32'(0));
    chk("rst_sop_eop", 32'({tx_if.o_sop, tx_if.o_eop}), 32'(0));
    tick();
    rst = 1'b0; s_rst = 1'b0;

    // addr-indexed frame, then out-of-range writes that must vanish silently
    for (int a = 0; a < NP; a++) write_pix(4'(a), {8'(8'hA0 + a), 8'(a)});
    for (int a = NP; a < 16; a++) write_pix(4'(a), pix_t'($urandom));
    @(negedge clk);
    chk("oor_no_err", 32'(m_err), 32'(0));
    tick();

    // full-rate frame: latency, gapless beats, framing, done timing
    t0 = cyc; first = -1; nvalid = 0; eop_c = -1; done_c = -1; first_sop = 1'b0; last_d = '0;
    pulse_start();
    repeat (20) begin
      @(negedge clk);
      if (tx_if.o_valid) begin
        if (first < 0) begin first = cyc; first_sop = tx_if.o_sop; end
        nvalid++;
        if (tx_if.o_eop) begin eop_c = cyc; last_d = tx_if.o_data; end
      end
      if (m_done && done_c < 0) done_c = cyc;
      tick();
    end
    chk("first_valid_latency", 32'(first - t0), 32'(2));
    chk("first_beat_sop", 32'(first_sop), 32'(1));
    chk("valid_beats", 32'(nvalid), 32'(12));
    chk("eop_offset", 32'(eop_c - first), 32'(11));
    chk("done_offset", 32'(done_c - t0), 32'(14));
    chk("last_pixel", 32'(last_d), 32'h0000AB0B);

    // same frame under random backpressure
    pulse_start();
    run_frame(200, 1'b1, "bp_frame_done");

    // clk_en low for 5 cycles mid-frame
    pulse_start();
    repeat (6) tick();
    clk_en = 1'b0;
    repeat (5) begin ready = 1'($urandom_range(0, 1)); tick(); end
    clk_en = 1'b1; ready = 1'b1;
    run_frame(40, 1'b0, "clken_frame_done");

    // write during RUN is dropped and flags the sticky error
    pulse_start();
    repeat (3) tick();
    write_pix(4'd3, 16'hFFFF);
    run_frame(40, 1'b1, "wr_busy_frame_done");
    @(negedge clk);
    chk("wr_err_set", 32'(m_err), 32'(1));
    tick();
    pulse_start();
    run_frame(200, 1'b1, "replay_frame_done");
    @(negedge clk);
    chk("wr_err_sticky", 32'(m_err), 32'(1));
    tick();

    // reset while beat 6 is presented, then a clean restart
    pulse_start();
    n = 0;
    for (int k = 0; k < 40 && n < 6; k++) begin
      @(negedge clk);
      if (tx_if.o_valid && ready) n++;
      tick();
    end
    chk("beats_before_rst", 32'(n), 32'(6));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(tx_if.o_valid), 32'(0));
    chk("post_rst_busy", 32'(m_busy), 32'(0));
    tick();
    pulse_start();
    run_frame(40, 1'b0, "restart_frame_done");

    // random contents, last write colliding with start on address 0
    for (int r = 0; r < 2; r++) begin
      for (int a = 1; a < NP; a++) write_pix(4'(a), pix_t'($urandom));
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = pix_t'($urandom); start = 1'b1;
      tick();
      wr_en = 1'b0; start = 1'b0;
      run_frame(200, 1'b1, "rand_frame_done");
    end
    repeat (3) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'(0));

    // 1x1 image: one beat carrying both sop and eop
    s_wr_en = 1'b1; s_wr_addr = 1'b0; s_wr_data = 8'h5A;
    tick();
    s_wr_en = 1'b0; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    @(negedge clk);
    chk("s_wait_valid", 32'(s_if.o_valid), 32'(0));
    chk("s_busy", 32'(s_busy), 32'(1));
    tick();
    @(negedge clk);
    chk("s_beat", 32'({s_if.o_valid, s_if.o_sop, s_if.o_eop, s_if.o_data}), 32'h0000075A);
    tick();
    @(negedge clk);
    chk("s_after", 32'({s_if.o_valid, s_busy, s_done}), 32'(1));
    tick();
`ifdef PIX_TX_LOOP_EN
    // looping 1x1: a sop+eop beat on every cycle until i_loop drops
    s_loop = 1'b1; s_wr_en = 1'b1; s_wr_data = 8'h3C; s_start = 1'b1;
    tick();
    s_wr_en = 1'b0; s_start = 1'b0;
    tick();
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("s_loop_beat", 32'({s_if.o_valid, s_if.o_sop, s_if.o_eop, s_if.o_data}), 32'h0000073C);
      chk("s_loop_busy", 32'(s_busy), 32'(1));
      if (j > 0) chk("s_loop_done", 32'(s_done), 32'(1));
      tick();
    end
    s_loop = 1'b0;
    @(negedge clk);
    chk("s_loop_last", 32'(s_if.o_valid), 32'(1));
    tick();
    @(negedge clk);
    chk("s_loop_end", 32'({s_if.o_valid, s_busy, s_done}), 32'(1));
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
